// File: rtl/ecg_acq_ctrl_pkg.sv
// Shared types for the multi-channel ECG acquisition controller.
package ecg_acq_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONVST,
    WAIT,
    FETCH,
    EMIT
  } acq_state_e;

  typedef enum logic {
    SRC_ADC  = 1'b0,
    SRC_FIFO = 1'b1
  } ecg_src_e;

  localparam int unsigned ACQ_NCH = 4;

  // Index width for n items, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ecg_acq_ctrl.sv
// Per-tick frame acquisition from ADC / din FIFOs, streamed out one channel
// per valid/ready beat with frame counter and sticky error flags.
module ecg_acq_ctrl
  import ecg_acq_ctrl_pkg::*;
#(
  parameter int unsigned NCH        = ACQ_NCH,
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned CTR_WIDTH  = 24,
  parameter int unsigned CONVST_LEN = 4,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_tick,
  input  logic                      i_en,
  input  logic [NCH-1:0]            i_src_sel,
  input  logic                      i_new_record,
  input  logic                      i_clr_flags,
  output logic                      o_adc_convst,
  input  logic                      i_adc_busy,
  input  logic [NCH*DATA_WIDTH-1:0] i_adc_data,
  input  logic                      i_adc_rd_valid,
  output logic [NCH-1:0]            o_fifo_pop,
  input  logic [NCH-1:0]            i_fifo_empty,
  input  logic [NCH*DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic [NCH-1:0]            i_fifo_rd_valid,
  output logic [DATA_WIDTH-1:0]     o_sample,
  output logic [idx_width(NCH)-1:0] o_sample_ch,
  output logic                      o_sample_valid,
  input  logic                      i_sample_ready,
  output logic [CTR_WIDTH-1:0]      o_ctr,
  output logic                      o_frame_done,
  output logic                      o_overrun,
  output logic [NCH-1:0]            o_underrun,
  output logic                      o_adc_timeout
);

  localparam int unsigned CH_W = idx_width(NCH);
  localparam int unsigned CV_W = (CONVST_LEN > 1) ? $clog2(CONVST_LEN) : 1;
  localparam int unsigned TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  acq_state_e            state;
  logic [NCH-1:0]        src_q;
  logic                  adc_pend, adc_pend_nxt;
  logic [NCH-1:0]        fifo_pend, fifo_pend_nxt;
  logic [DATA_WIDTH-1:0] hold_q   [NCH];
  logic [DATA_WIDTH-1:0] hold_nxt [NCH];
  logic [CV_W-1:0]       cv_cnt;
  logic [TO_W-1:0]       to_cnt;
  logic [CH_W-1:0]       idx;
  logic [CH_W-1:0]       idx_nxt;
  logic                  rec_pend;
  logic                  start, any_adc, adc_win, fifo_win;
  logic                  all_done, timeout_hit;
  logic [NCH-1:0]        pop_mask, under_mask;
  logic                  unused_busy;

  assign unused_busy = i_adc_busy;
  assign start       = (state == IDLE) && i_tick && i_en;
  assign any_adc     = ~&i_src_sel;
  assign pop_mask    = i_src_sel & ~i_fifo_empty;
  assign under_mask  = i_src_sel & i_fifo_empty;
  assign adc_win     = (state == WAIT) || (state == FETCH);
  // FIFO data popped at frame start can come back while convst is still high.
  assign fifo_win    = adc_win || (state == CONVST);
  assign idx_nxt     = idx + CH_W'(1);

  // Holding-register bank capture and pending-channel bookkeeping.
  always_comb begin
    hold_nxt      = hold_q;
    adc_pend_nxt  = adc_pend;
    fifo_pend_nxt = fifo_pend;
    for (int k = 0; k < int'(NCH); k++) begin
      if (adc_win && adc_pend && i_adc_rd_valid && (src_q[k] == SRC_ADC))
        hold_nxt[k] = i_adc_data[k*DATA_WIDTH +: DATA_WIDTH];
      if (fifo_win && fifo_pend[k] && i_fifo_rd_valid[k]) begin
        hold_nxt[k]      = i_fifo_rdata[k*DATA_WIDTH +: DATA_WIDTH];
        fifo_pend_nxt[k] = 1'b0;
      end
    end
    if (adc_win && i_adc_rd_valid) adc_pend_nxt = 1'b0;
  end

  assign all_done    = !adc_pend_nxt && (fifo_pend_nxt == '0);
  assign timeout_hit = adc_win && !all_done && (to_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      src_q          <= '0;
      adc_pend       <= 1'b0;
      fifo_pend      <= '0;
      hold_q         <= '{default: '0};
      cv_cnt         <= '0;
      to_cnt         <= '0;
      idx            <= '0;
      rec_pend       <= 1'b0;
      o_adc_convst   <= 1'b0;
      o_fifo_pop     <= '0;
      o_sample       <= '0;
      o_sample_ch    <= '0;
      o_sample_valid <= 1'b0;
      o_ctr          <= '0;
      o_frame_done   <= 1'b0;
      o_overrun      <= 1'b0;
      o_underrun     <= '0;
      o_adc_timeout  <= 1'b0;
    end else begin
      o_frame_done  <= 1'b0;
      o_fifo_pop    <= '0;
      hold_q        <= hold_nxt;
      adc_pend      <= adc_pend_nxt;
      fifo_pend     <= fifo_pend_nxt;
      // Sticky flags: a set in the same cycle as a clear wins.
      o_overrun     <= (o_overrun & ~i_clr_flags) | (i_tick && (state != IDLE));
      o_underrun    <= (o_underrun & ~{NCH{i_clr_flags}}) | (start ? under_mask : '0);
      o_adc_timeout <= (o_adc_timeout & ~i_clr_flags) | timeout_hit;
      if (i_new_record && (state != IDLE)) rec_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (i_new_record) o_ctr <= '0;
          if (start) begin
            src_q      <= i_src_sel;
            adc_pend   <= any_adc;
            fifo_pend  <= pop_mask;
            o_fifo_pop <= pop_mask;
            to_cnt     <= '0;
            cv_cnt     <= '0;
            if (any_adc) begin
              state        <= CONVST;
              o_adc_convst <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        CONVST: begin
          if (cv_cnt == CV_W'(CONVST_LEN - 1)) begin
            o_adc_convst <= 1'b0;
            to_cnt       <= '0;
            state        <= WAIT;
          end else begin
            cv_cnt <= cv_cnt + CV_W'(1);
          end
        end
        WAIT, FETCH: begin
          if (all_done || timeout_hit) begin
            adc_pend       <= 1'b0;
            fifo_pend      <= '0;
            idx            <= '0;
            o_sample       <= hold_nxt[0];
            o_sample_ch    <= '0;
            o_sample_valid <= 1'b1;
            state          <= EMIT;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        EMIT: begin
          if (i_sample_ready) begin
            if (idx == CH_W'(NCH - 1)) begin
              o_sample_valid <= 1'b0;
              o_frame_done   <= 1'b1;
              o_ctr          <= (rec_pend || i_new_record) ? '0 : o_ctr + CTR_WIDTH'(1);
              rec_pend       <= 1'b0;
              state          <= IDLE;
            end else begin
              idx         <= idx_nxt;
              o_sample    <= hold_q[idx_nxt];
              o_sample_ch <= idx_nxt;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ecg_acq_ctrl.sv
// Self-checking bench for ecg_acq_ctrl: vector table, hand sequences and a
// randomized section, all checked against a frame-level reference model.
module tb_ecg_acq_ctrl;

  logic        clk = 1'b0;
  logic        rst, tick, en, new_record, clr_flags, sample_ready;
  logic        adc_rd_valid, adc_busy;
  logic [3:0]  src_sel, fifo_empty, fifo_rd_valid;
  logic [47:0] adc_data, fifo_rdata;

  logic        convst, sample_valid, frame_done, overrun, adc_timeout;
  logic [3:0]  fifo_pop, underrun;
  logic [11:0] sample;
  logic [1:0]  sample_ch;
  logic [23:0] ctr;

  logic        convst2, sample_valid2, frame_done2, overrun2, adc_timeout2;
  logic [3:0]  fifo_pop2, underrun2, ctr2;
  logic [11:0] sample2;
  logic [1:0]  sample_ch2;

  always #5 clk = ~clk;

  ecg_acq_ctrl u_dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_en(en), .i_src_sel(src_sel),
    .i_new_record(new_record), .i_clr_flags(clr_flags), .o_adc_convst(convst),
    .i_adc_busy(adc_busy), .i_adc_data(adc_data), .i_adc_rd_valid(adc_rd_valid),
    .o_fifo_pop(fifo_pop), .i_fifo_empty(fifo_empty), .i_fifo_rdata(fifo_rdata),
    .i_fifo_rd_valid(fifo_rd_valid), .o_sample(sample), .o_sample_ch(sample_ch),
    .o_sample_valid(sample_valid), .i_sample_ready(sample_ready), .o_ctr(ctr),
    .o_frame_done(frame_done), .o_overrun(overrun), .o_underrun(underrun),
    .o_adc_timeout(adc_timeout)
  );

  // Narrow-counter instance sharing all stimulus, used for the wrap check.
  ecg_acq_ctrl #(.CTR_WIDTH(4)) u_dut_w4 (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_en(en), .i_src_sel(src_sel),
    .i_new_record(new_record), .i_clr_flags(clr_flags), .o_adc_convst(convst2),
    .i_adc_busy(adc_busy), .i_adc_data(adc_data), .i_adc_rd_valid(adc_rd_valid),
    .o_fifo_pop(fifo_pop2), .i_fifo_empty(fifo_empty), .i_fifo_rdata(fifo_rdata),
    .i_fifo_rd_valid(fifo_rd_valid), .o_sample(sample2), .o_sample_ch(sample_ch2),
    .o_sample_valid(sample_valid2), .i_sample_ready(sample_ready), .o_ctr(ctr2),
    .o_frame_done(frame_done2), .o_overrun(overrun2), .o_underrun(underrun2),
    .o_adc_timeout(adc_timeout2)
  );

  typedef struct packed {
    logic [1:0]  ch;
    logic [11:0] s;
    logic [23:0] ctr;
  } beat_t;

  typedef struct {
    logic [3:0]  sel;
    logic [3:0]  fill;
    int          lat;
    logic [11:0] adc_mul;
    logic [11:0] fifo_base;
    int          exp_lat;
    int          exp_cv;
    logic [3:0]  exp_under;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment: ADC responder and per-channel din FIFOs.
  logic [11:0] adc_val [4];
  int          adc_lat = 0;
  int          adc_cnt = 0;
  bit          adc_armed = 0;
  bit          cv_prev = 0;
  logic [11:0] fq [4][$];
  logic [11:0] pop_data [4];
  bit          pop_pend [4];
  bit          rand_rdy = 0;

  // Monitor-owned observations.
  beat_t got [$];
  int    fd_cnt = 0;
  int    cv_seen = 0;
  int    pop_cnt [4] = '{0, 0, 0, 0};

  // Reference model state.
  beat_t       exp_q [$];
  logic [11:0] last [4];
  logic [23:0] m_ctr;
  bit          m_rec;
  logic [3:0]  m_under;
  int          gb, fd0, cv0, n_lat;
  int          p0 [4];

  always @(negedge clk) begin
    if (!rst) begin
      if (sample_valid && sample_ready) got.push_back('{ch: sample_ch, s: sample, ctr: ctr});
      if (frame_done) fd_cnt++;
      if (convst) cv_seen++;
      for (int k = 0; k < 4; k++) if (fifo_pop[k]) pop_cnt[k]++;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    adc_rd_valid = 1'b0;
    if (adc_armed) begin
      adc_cnt++;
      if (adc_cnt == adc_lat) begin
        for (int k = 0; k < 4; k++) adc_data[k*12 +: 12] = adc_val[k];
        adc_rd_valid = 1'b1;
        adc_armed    = 0;
      end
    end
    if (convst && !cv_prev && adc_lat > 0) begin
      adc_armed = 1;
      adc_cnt   = 0;
    end
    cv_prev  = convst;
    adc_busy = adc_armed;
    for (int k = 0; k < 4; k++) begin
      fifo_rd_valid[k] = pop_pend[k];
      if (pop_pend[k]) fifo_rdata[k*12 +: 12] = pop_data[k];
      pop_pend[k] = 0;
      if (fifo_pop[k] && fq[k].size() > 0) begin
        pop_data[k] = fq[k].pop_front();
        pop_pend[k] = 1;
      end
      fifo_empty[k] = (fq[k].size() == 0);
    end
    if (rand_rdy) sample_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic preload(input logic [3:0] mask, input logic [11:0] base);
    for (int k = 0; k < 4; k++) begin
      if (mask[k]) fq[k].push_back(12'(base + 12'(k)));
      fifo_empty[k] = (fq[k].size() == 0);
    end
  endtask

  task automatic clr();
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    m_under   = '0;
  endtask

  // Frame-level prediction: what each channel should carry this frame.
  task automatic predict(input logic [3:0] sel);
    logic [11:0] v;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      if (!sel[k])                v = (adc_lat > 0) ? adc_val[k] : last[k];
      else if (fq[k].size() > 0)  v = fq[k][0];
      else begin
        v          = last[k];
        m_under[k] = 1'b1;
      end
      last[k] = v;
      exp_q.push_back('{ch: 2'(k), s: v, ctr: m_ctr});
    end
  endtask

  task automatic start_frame(input logic [3:0] sel);
    predict(sel);
    gb  = got.size();
    fd0 = fd_cnt;
    cv0 = cv_seen;
    for (int k = 0; k < 4; k++) p0[k] = pop_cnt[k];
    src_sel = sel;
    tick    = 1'b1;
    step();
    tick    = 1'b0;
    n_lat   = 1;
  endtask

  task automatic wait_valid();
    while (!sample_valid && n_lat < 3000) begin
      step();
      n_lat++;
    end
    if (!sample_valid) chk("valid_wait_expired", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 5000) begin
      step();
      n++;
    end
    if (!frame_done) chk("frame_done_wait_expired", 0, 1);
    m_ctr = m_rec ? 24'd0 : m_ctr + 24'd1;
    m_rec = 0;
    step();
    chk("frame_done_once", fd_cnt - fd0, 1);
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_beats"}, got.size() - gb, exp_q.size());
    for (int i = 0; i < exp_q.size() && gb + i < got.size(); i++) begin
      chk({tag, "_ch"},  got[gb+i].ch,  exp_q[i].ch);
      chk({tag, "_val"}, got[gb+i].s,   exp_q[i].s);
      chk({tag, "_ctr"}, got[gb+i].ctr, exp_q[i].ctr);
    end
  endtask

  function automatic logic [3:0] pops_seen();
    logic [3:0] m;
    for (int k = 0; k < 4; k++) m[k] = (pop_cnt[k] != p0[k]);
    return m;
  endfunction

  initial begin
    vec_t vt [6];
    logic [11:0] s1;
    logic [3:0]  sel, fill;

    vt[0] = '{4'b0000, 4'b0000, 20, 12'h111, 12'h000, 22, 4, 4'b0000};
    vt[1] = '{4'b1111, 4'b1111,  0, 12'h000, 12'h005,  3, 0, 4'b0000};
    vt[2] = '{4'b0011, 4'b0001, 10, 12'h0A5, 12'h020, 12, 4, 4'b0010};
    vt[3] = '{4'b1010, 4'b1010,  6, 12'h123, 12'h040,  8, 4, 4'b0000};
    vt[4] = '{4'b1111, 4'b0000,  0, 12'h000, 12'h000,  2, 0, 4'b1111};
    vt[5] = '{4'b0101, 4'b0001,  4, 12'h301, 12'h060,  6, 4, 4'b0100};

    rst = 1'b1; tick = 0; en = 1; new_record = 0; clr_flags = 0; sample_ready = 1;
    adc_rd_valid = 0; adc_busy = 0; src_sel = '0; fifo_empty = '1;
    fifo_rd_valid = '0; adc_data = '0; fifo_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      last[k] = '0; pop_pend[k] = 0; pop_data[k] = '0; adc_val[k] = '0;
    end
    m_ctr = '0; m_rec = 0; m_under = '0;
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_valid", sample_valid, 0);
    chk("rst_convst", convst, 0);
    chk("rst_pop", fifo_pop, 0);
    chk("rst_ctr", ctr, 0);
    chk("rst_sample", sample, 0);
    chk("rst_flags", {overrun, underrun, adc_timeout, frame_done}, 0);

    foreach (vt[i]) begin
      clr();
      sample_ready = 1'b1;
      preload(vt[i].fill, vt[i].fifo_base);
      for (int k = 0; k < 4; k++) adc_val[k] = 12'(vt[i].adc_mul * 12'(k + 1));
      adc_lat = vt[i].lat;
      start_frame(vt[i].sel);
      wait_valid();
      chk("vec_latency", n_lat, vt[i].exp_lat);
      wait_done();
      cmp_beats("vec");
      chk("vec_convst_cycles", cv_seen - cv0, vt[i].exp_cv);
      chk("vec_pops", pops_seen(), vt[i].fill);
      chk("vec_underrun", underrun, vt[i].exp_under);
      chk("vec_timeout", adc_timeout, 0);
      chk("vec_overrun", overrun, 0);
    end

    // Stall with ready 1-0-0-1, extra tick and new_record during EMIT.
    clr();
    preload(4'b1111, 12'h009);
    sample_ready = 1'b0;
    start_frame(4'b1111);
    wait_valid();
    chk("stall_first_ch", sample_ch, 0);
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    tick = 1'b1; new_record = 1'b1; m_rec = 1;
    step();
    tick = 1'b0; new_record = 1'b0;
    s1 = sample;
    chk("stall_ch1", sample_ch, 1);
    chk("stall_val1", s1, exp_q[1].s);
    step();
    chk("stall_stable_val", sample, s1);
    chk("stall_stable_ch", sample_ch, 1);
    chk("stall_valid_held", sample_valid, 1);
    chk("overrun_set", overrun, 1);
    sample_ready = 1'b1;
    wait_done();
    cmp_beats("stall");
    chk("new_record_ctr", ctr, m_ctr);

    // ADC never answers: timeout, held values emitted, flag clearable.
    clr();
    adc_lat = 0;
    start_frame(4'b0000);
    wait_valid();
    chk("timeout_latency", n_lat, 4 + 1023 + 1);
    chk("timeout_flag", adc_timeout, 1);
    wait_done();
    cmp_beats("timeout");
    clr();
    chk("timeout_cleared", adc_timeout, 0);

    // Enable dropped mid-frame: frame finishes, no new frame starts.
    preload(4'b1111, 12'h070);
    start_frame(4'b1111);
    en = 1'b0;
    wait_valid();
    wait_done();
    cmp_beats("en_low");
    for (int k = 0; k < 4; k++) p0[k] = pop_cnt[k];
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (4) step();
    chk("en_low_no_valid", sample_valid, 0);
    chk("en_low_no_pop", pops_seen(), 0);
    chk("en_low_no_overrun", overrun, 0);
    en = 1'b1;

    // Randomized frames with random ready against the model.
    clr();
    rand_rdy = 1;
    for (int it = 0; it < 20; it++) begin
      sel  = 4'($urandom);
      fill = 4'($urandom) & sel;
      preload(fill, 12'($urandom));
      for (int k = 0; k < 4; k++) adc_val[k] = 12'($urandom);
      adc_lat = $urandom_range(4, 30);
      start_frame(sel);
      wait_valid();
      wait_done();
      cmp_beats("rand");
      chk("rand_underrun", underrun, m_under);
    end
    rand_rdy = 0;
    sample_ready = 1'b1;

    // 4-bit counter wraps 15 -> 0.
    new_record = 1'b1;
    step();
    new_record = 1'b0;
    m_ctr = '0;
    chk("wrap_start", ctr2, 0);
    for (int f = 0; f < 17; f++) begin
      start_frame(4'b1111);
      wait_valid();
      wait_done();
      chk((m_ctr[3:0] == 4'd0) ? "ctr_wrap_zero" : "ctr_w4", ctr2, m_ctr[3:0]);
    end
    chk("ctr_w24_no_wrap", ctr, 24'd17);

    // Reset during WAIT.
    adc_lat = 0;
    preload(4'b0001, 12'h0AA);
    start_frame(4'b0001);
    repeat (6) step();
    chk("pre_rst_valid", sample_valid, 0);
    rst = 1'b1;
    step();
    chk("rst_wait_convst", convst, 0);
    chk("rst_wait_pop", fifo_pop, 0);
    chk("rst_wait_valid", sample_valid, 0);
    chk("rst_wait_ctr", ctr, 0);
    chk("rst_wait_flags", {overrun, underrun, adc_timeout, frame_done}, 0);
    chk("rst_wait_sample", {sample, sample_ch}, 0);
    rst = 1'b0;
    adc_armed = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
